microseq_ctrl: RTL and testbench
================================

MICROSEQ_CTRL -- requirements
Module: microseq_ctrl

Interface
REQ-001 Parameter AW, default 11: microaddress width; matches the microaddr counter load/address width.
REQ-002 Parameter CW, default 8: control-field width of a microword.
REQ-003 Parameter SDEPTH, default 4: return-stack depth in entries; legal range 2..8.
REQ-004 Microword width SHALL be UW = 5+AW+CW, with fields [UW-1:UW-3] op, [UW-4:UW-5] csel, [AW+CW-1:CW] target, [CW-1:0] ctrl.
REQ-005 iCLK  input  1  the single clock; all state changes on its rising edge.
REQ-006 iRESET  input  1  synchronous, active-high reset.
REQ-007 iUADDR  input  AW  current microaddress driven by the microaddr counter.
REQ-008 iUWORD  input  UW  microword at iUADDR, from an asynchronous-read ROM, valid in the same cycle.
REQ-009 iCOND  input  4  condition flags; csel selects one of them.
REQ-010 iSTALL  input  1  freeze request from the datapath.
REQ-011 iRESTART  input  1  leave HALT/ERR and restart at address 0.
REQ-012 oCMD  output  2  counter command: 00 HOLD, 01 INC, 10 LOAD, 11 CLR.
REQ-013 oLDADR  output  AW  load address; meaningful only when oCMD=LOAD, 0 otherwise.
REQ-014 oCTRL  output  CW  control field of the executing microword.
REQ-015 oHALTED, oERR  output  1 each  state flags; oSP  output  4  stack entry count.

Function
REQ-016 States SHALL be RUN, DLY, HALT, ERR; oCMD, oLDADR and oCTRL SHALL be combinational from state, iUWORD, iCOND, iSTALL; stack, counters and state are registered.
REQ-017 Ops SHALL decode as 0 NEXT, 1 JMP, 2 JCOND, 3 CALL, 4 RET, 5 WAITC, 6 DELAY, 7 HALT.
REQ-018 In RUN: NEXT->INC; JMP->LOAD target; JCOND->LOAD target if iCOND[csel] else INC; WAITC->HOLD until iCOND[csel]=1, then INC in that same cycle.
REQ-019 CALL SHALL push (iUADDR+1) mod 2^AW and LOAD target; RET SHALL pop and LOAD the popped address.
REQ-020 CALL with oSP=SDEPTH, or RET with oSP=0, SHALL issue HOLD, leave the stack unchanged, and enter ERR next cycle.
REQ-021 DELAY N (N=target[7:0]): N=0->INC; otherwise HOLD, load the down-counter with N, and enter DLY.
REQ-022 In DLY: if the counter is 1, INC and return to RUN; else HOLD and decrement. Total occupancy of the address is N+1 cycles.
REQ-023 HALT op SHALL issue HOLD and enter HALT; HALT and ERR SHALL issue HOLD with oCTRL=0.
REQ-024 iRESTART in HALT or ERR SHALL issue CLR, clear the stack and oERR, and enter RUN next cycle; iRESTART SHALL be ignored in RUN and DLY.
REQ-025 iSTALL=1 in RUN or DLY SHALL force HOLD with no stack, counter or state change; oCTRL SHALL still show the ctrl field; iSTALL SHALL have priority over every op.
REQ-026 NEXT at iUADDR=2^AW-1 SHALL issue INC, and the counter wraps to 0; a CALL there SHALL push 0.
REQ-027 oHALTED=1 iff state HALT; oERR=1 iff state ERR.

Reset
REQ-028 iRESET SHALL force state RUN, an empty stack (oSP=0), down-counter 0, oHALTED=0 and oERR=0, with priority over iRESTART and iSTALL.
REQ-029 While iRESET=1, oCMD SHALL be CLR, oLDADR 0 and oCTRL 0; a reset during DLY or WAITC SHALL abandon that op.

Configuration
REQ-030 With macro MICROSEQ_STACK_EN defined, CALL/RET and the stack SHALL behave per REQ-019/020.
REQ-031 Without MICROSEQ_STACK_EN, there SHALL be no stack storage, CALL SHALL act as JMP, RET as NEXT, oSP SHALL be 0, and ERR SHALL be unreachable.

Verification
REQ-032 Reset then NEXT words at 0..3 -> oCMD=CLR during reset, then INC each cycle; iUADDR sequence 0,1,2,3,4.
REQ-033 JCOND csel=2 target=0x100: iCOND=0100 -> LOAD 0x100; iCOND=0000 -> INC.
REQ-034 DELAY 3 at address 5 -> HOLD for 3 cycles, INC on the 4th; with iSTALL high for 2 of those cycles -> INC on the 6th.
REQ-035 With MICROSEQ_STACK_EN and SDEPTH=4: five nested CALLs -> oSP=4, then HOLD and oERR=1; iRESTART -> CLR and oSP=0. RET at oSP=0 -> oERR=1.
REQ-036 CALL at 0x7FF targeting 0x010, then RET -> LOAD 0x000; HALT op -> oHALTED=1 and HOLD until iRESTART, then CLR.

Source files
------------

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: decodes the current microword into a command for an external microaddress counter.
// Optional return stack for CALL/RET is enabled by defining MICROSEQ_STACK_EN.
module microseq_ctrl #(
  parameter  int AW     = 11,
  parameter  int CW     = 8,
  parameter  int SDEPTH = 4,
  localparam int UW     = 5 + AW + CW
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic [AW-1:0] iUADDR,
  input  logic [UW-1:0] iUWORD,
  input  logic [3:0]    iCOND,
  input  logic          iSTALL,
  input  logic          iRESTART,
  output logic [1:0]    oCMD,
  output logic [AW-1:0] oLDADR,
  output logic [CW-1:0] oCTRL,
  output logic          oHALTED,
  output logic          oERR,
  output logic [3:0]    oSP
);

  typedef enum logic [1:0] {S_RUN, S_DLY, S_HALT, S_ERR} state_t;
  typedef enum logic [1:0] {CMD_HOLD = 2'b00, CMD_INC = 2'b01, CMD_LOAD = 2'b10, CMD_CLR = 2'b11} cmd_t;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JMP, OP_JCOND, OP_CALL, OP_RET, OP_WAITC, OP_DELAY, OP_HALT
  } op_t;

  state_t        state, state_nxt;
  logic [7:0]    dly_cnt;
  op_t           op;
  logic [AW-1:0] target;
  logic [CW-1:0] ctrl_f;
  logic [7:0]    dly_n;
  logic          cond;
  logic          run_go;
  logic          stk_full, stk_empty;
  logic [AW-1:0] ret_addr;

  assign op     = op_t'(iUWORD[UW-1 -: 3]);
  assign target = iUWORD[AW+CW-1:CW];
  assign ctrl_f = iUWORD[CW-1:0];
  assign dly_n  = target[7:0];
  assign cond   = iCOND[iUWORD[UW-4 -: 2]];
  assign run_go = (state == S_RUN) && !iSTALL && !iRESET;

`ifdef MICROSEQ_STACK_EN
  localparam int SW = $clog2(SDEPTH);
  logic [AW-1:0] stack [SDEPTH];
  logic [3:0]    sp;
  logic          push, pop, stk_clr;

  assign stk_full  = (sp == 4'(SDEPTH));
  assign stk_empty = (sp == 4'd0);
  assign ret_addr  = stack[SW'(sp - 4'd1)];
  assign push      = run_go && (op == OP_CALL) && !stk_full;
  assign pop       = run_go && (op == OP_RET) && !stk_empty;
  assign stk_clr   = ((state == S_HALT) || (state == S_ERR)) && iRESTART;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRESET || stk_clr) sp <= '0;
    else if (push)         sp <= sp + 4'd1;
    else if (pop)          sp <= sp - 4'd1;
  end

  // NOTE: stack storage is not reset; sp alone defines which entries are valid.
  always_ff @(posedge iCLK) begin
    if (push) stack[SW'(sp)] <= iUADDR + AW'(1);
  end

  assign oSP = sp;
`else
  logic unused_uaddr;
  assign unused_uaddr = ^iUADDR;
  assign stk_full     = 1'b0;
  assign stk_empty    = 1'b0;
  assign ret_addr     = '0;
  assign oSP          = 4'd0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET)                             dly_cnt <= 8'd0;
    else if (run_go && op == OP_DELAY)      dly_cnt <= dly_n;
    else if (state == S_DLY && !iSTALL)     dly_cnt <= dly_cnt - 8'd1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN: if (!iSTALL) begin
        if (op == OP_HALT)                                      state_nxt = S_HALT;
        else if (op == OP_DELAY && dly_n != 8'd0)               state_nxt = S_DLY;
        else if ((op == OP_CALL && stk_full) || (op == OP_RET && stk_empty))
                                                                state_nxt = S_ERR;
      end
      S_DLY:          if (!iSTALL && dly_cnt == 8'd1) state_nxt = S_RUN;
      S_HALT, S_ERR:  if (iRESTART)                   state_nxt = S_RUN;
      default:                                        state_nxt = S_RUN;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    oCMD   = CMD_HOLD;
    oLDADR = '0;
    oCTRL  = '0;
    if (iRESET) begin
      oCMD = CMD_CLR;
    end else begin
      unique case (state)
        S_RUN: begin
          oCTRL = ctrl_f;
          if (!iSTALL) begin
            unique case (op)
              OP_NEXT:  oCMD = CMD_INC;
              OP_JMP:   begin oCMD = CMD_LOAD; oLDADR = target; end
              OP_JCOND: if (cond) begin oCMD = CMD_LOAD; oLDADR = target; end
                        else oCMD = CMD_INC;
              OP_CALL:  if (!stk_full) begin oCMD = CMD_LOAD; oLDADR = target; end
`ifdef MICROSEQ_STACK_EN
              OP_RET:   if (!stk_empty) begin oCMD = CMD_LOAD; oLDADR = ret_addr; end
`else
              OP_RET:   oCMD = CMD_INC;
`endif
              OP_WAITC: if (cond) oCMD = CMD_INC;
              OP_DELAY: if (dly_n == 8'd0) oCMD = CMD_INC;
              OP_HALT:  oCMD = CMD_HOLD;
              default:  oCMD = CMD_HOLD;
            endcase
          end
        end
        S_DLY: begin
          oCTRL = ctrl_f;
          if (!iSTALL && dly_cnt == 8'd1) oCMD = CMD_INC;
        end
        S_HALT, S_ERR: if (iRESTART) oCMD = CMD_CLR;
        default: oCMD = CMD_HOLD;
      endcase
    end
  end

  assign oHALTED = (state == S_HALT);
  assign oERR    = (state == S_ERR);

endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl: a behavioural model plus a microaddress counter/ROM environment.
// Directed programs cover the documented scenarios, then randomized ROM contents and inputs.
module tb_microseq_ctrl;
  localparam int AW = 11;
  localparam int CW = 8;
  localparam int SDEPTH = 4;
  localparam int UW = 5 + AW + CW;

  localparam logic [1:0] C_HOLD = 2'b00, C_INC = 2'b01, C_LOAD = 2'b10, C_CLR = 2'b11;
  localparam int M_RUN = 0, M_DLY = 1, M_HALT = 2, M_ERR = 3;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] ldadr;
    logic [CW-1:0] ctrl;
    logic          halted;
    logic          err;
    logic [3:0]    sp;
  } exp_t;

  logic          iCLK, iRESET, iSTALL, iRESTART;
  logic [AW-1:0] iUADDR;
  logic [UW-1:0] iUWORD;
  logic [3:0]    iCOND;
  logic [1:0]    oCMD;
  logic [AW-1:0] oLDADR;
  logic [CW-1:0] oCTRL;
  logic          oHALTED, oERR;
  logic [3:0]    oSP;

  microseq_ctrl #(.AW(AW), .CW(CW), .SDEPTH(SDEPTH)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iUADDR(iUADDR), .iUWORD(iUWORD), .iCOND(iCOND),
    .iSTALL(iSTALL), .iRESTART(iRESTART), .oCMD(oCMD), .oLDADR(oLDADR), .oCTRL(oCTRL),
    .oHALTED(oHALTED), .oERR(oERR), .oSP(oSP)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic [UW-1:0] rom [1 << AW];
  logic [AW-1:0] pc;
  int            m_mode;
  int            m_left;
  logic [AW-1:0] m_stack [$];
  exp_t          sb_q [$];
  string         tag_q [$];
  string         phase;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [UW-1:0] mk(input int op, input int csel, input int tgt, input int ctrl);
    logic [2:0] o; logic [1:0] c; logic [AW-1:0] t; logic [CW-1:0] k;
    o = 3'(op); c = 2'(csel); t = AW'(tgt); k = CW'(ctrl);
    return {o, c, t, k};
  endfunction

  task automatic fill_next();
    for (int i = 0; i < (1 << AW); i++) rom[i] = mk(0, 0, 0, i & 8'hFF);
  endtask

  // Reference model: stack is a queue, a delay is "cycles still to hold".
  task automatic model(input bit rst, st, rs, input logic [3:0] c,
                       input logic [AW-1:0] ua, input logic [UW-1:0] w, output exp_t e);
    int op, csel, n;
    logic [AW-1:0] tgt;
    logic [CW-1:0] cf;
    bit hit;
    op = int'(w[UW-1 -: 3]); csel = int'(w[UW-4 -: 2]);
    tgt = w[AW+CW-1:CW]; cf = w[CW-1:0]; hit = c[csel];
    e.cmd = C_HOLD; e.ldadr = '0; e.ctrl = '0;
    e.halted = (m_mode == M_HALT); e.err = (m_mode == M_ERR); e.sp = 4'(m_stack.size());
    if (rst) begin
      e.cmd = C_CLR; m_mode = M_RUN; m_stack.delete(); m_left = 0;
    end else if (m_mode == M_HALT || m_mode == M_ERR) begin
      if (rs) begin e.cmd = C_CLR; m_stack.delete(); m_mode = M_RUN; end
    end else if (m_mode == M_DLY) begin
      e.ctrl = cf;
      if (!st) begin
        if (m_left == 0) begin e.cmd = C_INC; m_mode = M_RUN; end
        else m_left--;
      end
    end else begin
      e.ctrl = cf;
      if (!st) case (op)
        0: e.cmd = C_INC;
        1: begin e.cmd = C_LOAD; e.ldadr = tgt; end
        2: if (hit) begin e.cmd = C_LOAD; e.ldadr = tgt; end else e.cmd = C_INC;
`ifdef MICROSEQ_STACK_EN
        3: if (m_stack.size() == SDEPTH) m_mode = M_ERR;
           else begin
             m_stack.push_back(AW'((int'(ua) + 1) % (1 << AW)));
             e.cmd = C_LOAD; e.ldadr = tgt;
           end
        4: if (m_stack.size() == 0) m_mode = M_ERR;
           else begin e.cmd = C_LOAD; e.ldadr = m_stack.pop_back(); end
`else
        3: begin e.cmd = C_LOAD; e.ldadr = tgt; end
        4: e.cmd = C_INC;
`endif
        5: if (hit) e.cmd = C_INC;
        6: begin
             n = int'(tgt[7:0]);
             if (n == 0) e.cmd = C_INC;
             else begin m_mode = M_DLY; m_left = n - 1; end
           end
        default: m_mode = M_HALT;
      endcase
    end
  endtask

  // One clock of stimulus: drive at the falling edge, queue the model's expectation, step the counter.
  task automatic cyc(input bit rst, input bit st, input bit rs, input logic [3:0] c);
    exp_t e;
    @(negedge iCLK);
    iRESET = rst; iSTALL = st; iRESTART = rs; iCOND = c;
    iUADDR = pc; iUWORD = rom[pc];
    model(rst, st, rs, c, pc, rom[pc], e);
    sb_q.push_back(e);
    tag_q.push_back(phase);
    case (e.cmd)
      C_INC:   pc = pc + AW'(1);
      C_LOAD:  pc = e.ldadr;
      C_CLR:   pc = '0;
      default: pc = pc;
    endcase
  endtask

  task automatic run(input int n, input bit st, input bit rs, input logic [3:0] c);
    for (int i = 0; i < n; i++) cyc(1'b0, st, rs, c);
  endtask

  task automatic check(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got cmd=%0d ld=%h ctrl=%h halt=%b err=%b sp=%0d, want cmd=%0d ld=%h ctrl=%h halt=%b err=%b sp=%0d",
               name, $time, act.cmd, act.ldadr, act.ctrl, act.halted, act.err, act.sp,
               exp.cmd, exp.ldadr, exp.ctrl, exp.halted, exp.err, exp.sp);
    end
  endtask

  // Monitor: every cycle the DUT presents a response; pop and compare when one is expected.
  initial begin
    exp_t a, x;
    string t;
    forever begin
      @(negedge iCLK);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        a.cmd = oCMD; a.ldadr = oLDADR; a.ctrl = oCTRL;
        a.halted = oHALTED; a.err = oERR; a.sp = oSP;
        check(t, a, x);
      end
    end
  end

  initial begin
    iRESET = 1'b1; iSTALL = 1'b0; iRESTART = 1'b0; iCOND = 4'h0;
    iUADDR = '0; iUWORD = '0;
    pc = '0; m_mode = M_RUN; m_left = 0;

    phase = "reset_next";
    fill_next();
    cyc(1, 0, 0, 4'h0); cyc(1, 1, 1, 4'hF);
    run(5, 0, 0, 4'h0);

    phase = "jcond";
    rom[0] = mk(2, 2, 'h100, 'hA5); rom['h100] = mk(1, 0, 0, 'h5A);
    cyc(1, 0, 0, 4'h0);
    run(1, 0, 0, 4'b0100); run(1, 0, 0, 4'b0000); run(2, 0, 0, 4'b1011);

    phase = "delay3";
    fill_next(); rom[5] = mk(6, 0, 3, 'h33); rom[6] = mk(5, 1, 0, 'h66);
    cyc(1, 0, 0, 4'h0); run(5, 0, 0, 4'h0); run(4, 0, 0, 4'h0);
    phase = "waitc";
    run(3, 0, 0, 4'b1101); run(1, 0, 0, 4'b0010); run(1, 0, 0, 4'h0);
    phase = "delay3_stall";
    cyc(1, 0, 0, 4'h0); run(5, 0, 0, 4'h0);
    run(1, 0, 0, 4'h0); run(1, 1, 0, 4'h0); run(1, 0, 0, 4'h0);
    run(1, 1, 1, 4'h0); run(2, 0, 0, 4'h0); run(1, 0, 0, 4'h0);
    phase = "delay_reset";
    cyc(1, 0, 0, 4'h0); run(6, 0, 0, 4'h0); cyc(1, 0, 0, 4'h0); run(3, 0, 0, 4'h0);
    phase = "delay0";
    rom[2] = mk(6, 0, 'h700, 'h22);
    cyc(1, 0, 0, 4'h0); run(4, 0, 0, 4'h0);

    phase = "halt";
    fill_next(); rom[1] = mk(7, 0, 0, 'h77);
    cyc(1, 0, 0, 4'h0); run(4, 1, 0, 4'h0); run(1, 0, 0, 4'h0);
    run(3, 0, 0, 4'hF); run(1, 1, 1, 4'h0); run(2, 0, 0, 4'h0);

    phase = "wrap_call_ret";
    fill_next(); rom[0] = mk(1, 0, 'h7FF, 'h01);
    cyc(1, 0, 0, 4'h0); run(3, 0, 0, 4'h0);
    rom['h7FF] = mk(3, 0, 'h010, 'hC1); rom['h10] = mk(4, 0, 0, 'hE1);
    cyc(1, 0, 0, 4'h0); run(5, 0, 0, 4'h0);

    phase = "nested_calls";
    fill_next(); rom[0] = mk(1, 0, 'h20, 0);
    for (int k = 0; k < 5; k++) rom['h20 + k] = mk(3, 0, 'h21 + k, 'h40 + k);
    cyc(1, 0, 0, 4'h0); run(8, 0, 0, 4'h0); run(1, 0, 1, 4'h0); run(2, 0, 0, 4'h0);
    phase = "ret_empty";
    rom[0] = mk(4, 0, 0, 'h99);
    cyc(1, 0, 0, 4'h0); run(3, 0, 0, 4'h0); run(1, 0, 1, 4'h0); run(1, 0, 0, 4'h0);

    phase = "random";
    for (int i = 0; i < (1 << AW); i++) begin
      int op;
      op = $urandom_range(0, 7);
      rom[i] = mk(op, $urandom_range(0, 3),
                  (op == 6) ? $urandom_range(0, 4) : $urandom_range(0, (1 << AW) - 1),
                  $urandom_range(0, 255));
    end
    cyc(1, 0, 0, 4'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));

    repeat (3) @(negedge iCLK);
    #4;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
